// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment lookup for the seven-segment display blocks.
// Patterns are active-low with bit0 = segment a through bit6 = segment g.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_hex_dec.sv
// Combinational single-digit hex decoder; usable on its own for static displays.
module seven_seg_hex_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = seg_hex(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode driver with a double-buffered display value,
// per-digit decimal points and optional leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    frame_done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic                  blank_lz;
  } disp_buf_t;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  disp_buf_t           pend_q, pend_d;
  disp_buf_t           act_q, act_d;
  disp_buf_t           live;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                cur_blank;
  logic [N_DIGITS-1:0] onehot;
  logic [6:0]          hex_seg;

  assign live = '{value: value, dp: dp_in, blank_lz: blank_lz};
  assign tick = (presc_q == PRESC_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  // Scan timing runs independently of en so re-enabling never resets the phase.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // A load coinciding with the frame boundary goes straight to the active buffer.
  always_comb begin
    pend_d = load ? live : pend_q;
    act_d  = act_q;
    if (wrap) begin
      act_d = load ? live : pend_q;
    end
  end

  // Select the current digit; a digit is blanked only when it and all digits above are zero.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    onehot     = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      onehot[k] = (idx_q == IW'(k));
      if (idx_q == IW'(k)) begin
        cur_nibble = act_q.value[4*k +: 4];
        cur_dp     = act_q.dp[k];
        cur_blank  = (k != 0) && act_q.blank_lz && ((act_q.value >> (4 * k)) == '0);
      end
    end
  end

  seven_seg_hex_dec u_hex_dec (
    .nibble (cur_nibble),
    .seg_n  (hex_seg)
  );

  always_comb begin
    seg_d = (!en || cur_blank) ? SEG_BLANK : hex_seg;
    dp_d  = en ? ~cur_dp : 1'b1;
    an_d  = en ? ~onehot : '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= wrap;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (4 digits, 4 clocks per slot) plus targeted pattern checks.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int          m_presc = 0;
  int          m_idx = 0;
  logic [15:0] m_pv = 16'h0, m_av = 16'h0;
  logic [3:0]  m_pd = 4'h0, m_ad = 4'h0;
  logic        m_pl = 1'b0, m_al = 1'b0;

  seven_seg_scan #(
    .N_DIGITS (4),
    .DIV      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // One clock edge: advance the reference model with the inputs seen at the edge and
  // queue the outputs the DUT must show after it.
  task automatic cyc();
    exp_t       e;
    logic       tk, wr, blank;
    logic [3:0] nib;
    @(posedge clk);
    if (!rst_n) begin
      m_presc = 0;
      m_idx   = 0;
      m_pv = 16'h0; m_pd = 4'h0; m_pl = 1'b0;
      m_av = 16'h0; m_ad = 4'h0; m_al = 1'b0;
      e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fd = 1'b0;
    end else begin
      tk    = (m_presc == 3);
      wr    = tk && (m_idx == 3);
      nib   = 4'(m_av >> (4 * m_idx));
      blank = m_al && (m_idx != 0) && (16'(m_av >> (4 * m_idx)) == 16'h0);
      e.seg = (!en || blank) ? 7'h7F : hex_ref(nib);
      e.dp  = en ? ~m_ad[m_idx] : 1'b1;
      e.an  = en ? ~(4'b0001 << m_idx) : 4'hF;
      e.fd  = wr;
      if (wr) begin
        if (load) begin
          m_av = value; m_ad = dp_in; m_al = blank_lz;
        end else begin
          m_av = m_pv; m_ad = m_pd; m_al = m_pl;
        end
      end
      if (load) begin
        m_pv = value; m_pd = dp_in; m_pl = blank_lz;
      end
      m_presc = tk ? 0 : m_presc + 1;
      if (tk) m_idx = (m_idx == 3) ? 0 : m_idx + 1;
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int j = 0; j < 2; j++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL reset_sb: got %h required %h", {seg_n, dp_n, an_n, frame_done},
                 {e.seg, e.dp, e.an, e.fd});
      end
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL reset_values: got seg=%h dp=%b an=%h fd=%b required 7f 1 f 0",
                 seg_n, dp_n, an_n, frame_done);
      end
    end
  endtask

  task automatic test_scan();
    exp_t       e;
    logic [3:0] an_exp;
    rst_n = 1'b1;
    for (int j = 0; j < 48; j++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL scan_sb: cycle %0d got %h required %h", j,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      an_exp = ~(4'b0001 << ((j / 4) % 4));
      checks++;
      if (an_n !== an_exp || seg_n !== 7'h40 || frame_done !== (j % 16 == 15)) begin
        failures++;
        $display("FAIL scan_pattern: cycle %0d got an=%h seg=%h fd=%b required an=%h seg=40 fd=%b",
                 j, an_n, seg_n, frame_done, an_exp, (j % 16 == 15));
      end
    end
  endtask

  task automatic test_load();
    exp_t       e;
    int         cw, s;
    logic [6:0] seg_tbl [4];
    seg_tbl = '{7'h0E, 7'h08, 7'h24, 7'h79};
    value = 16'h12AF; dp_in = 4'b0100; blank_lz = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
      failures++;
      $display("FAIL load_sb: got %h required %h", {seg_n, dp_n, an_n, frame_done},
               {e.seg, e.dp, e.an, e.fd});
    end
    cw = (3 - m_idx) * 4 + (3 - m_presc);
    for (int j = 0; j <= cw + 16; j++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL load_sb: cycle %0d got %h required %h", j,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      if (j > cw) begin
        s = (j - cw - 1) / 4;
        checks++;
        if (seg_n !== seg_tbl[s] || dp_n !== (s != 2) || an_n !== ~(4'b0001 << s)) begin
          failures++;
          $display("FAIL load_digits: slot %0d got seg=%h dp=%b an=%h required seg=%h dp=%b",
                   s, seg_n, dp_n, an_n, seg_tbl[s], (s != 2));
        end
      end
    end
  endtask

  task automatic test_blank();
    exp_t       e;
    int         cw, s;
    logic [6:0] want;
    for (int p = 0; p < 2; p++) begin
      value = (p == 0) ? 16'h0005 : 16'h0000;
      dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
      cyc();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL blank_sb: got %h required %h", {seg_n, dp_n, an_n, frame_done},
                 {e.seg, e.dp, e.an, e.fd});
      end
      cw = (3 - m_idx) * 4 + (3 - m_presc);
      for (int j = 0; j <= cw + 16; j++) begin
        cyc();
        e = sb.pop_front();
        checks++;
        if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
          failures++;
          $display("FAIL blank_sb: cycle %0d got %h required %h", j,
                   {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
        end
        if (j > cw) begin
          s    = (j - cw - 1) / 4;
          want = (s != 0) ? 7'h7F : ((p == 0) ? 7'h12 : 7'h40);
          checks++;
          if (seg_n !== want || dp_n !== 1'b1) begin
            failures++;
            $display("FAIL blank_digits: pass %0d slot %0d got seg=%h dp=%b required seg=%h dp=1",
                     p, s, seg_n, dp_n, want);
          end
        end
      end
    end
  endtask

  task automatic test_load_on_wrap();
    exp_t       e;
    int         cw;
    logic [6:0] want;
    blank_lz = 1'b0; dp_in = 4'h0;
    cw = (3 - m_idx) * 4 + (3 - m_presc);
    for (int j = 0; j <= cw; j++) begin
      if (j == cw) begin
        value = 16'h8888; load = 1'b1;
      end
      cyc();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL wrapload_sb: cycle %0d got %h required %h", j,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
    end
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        value = 16'h1234; load = 1'b1;
      end
      cyc();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL deferred_sb: cycle %0d got %h required %h", k,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      want = (k < 16) ? 7'h00 : 7'h19;
      checks++;
      if (seg_n !== want) begin
        failures++;
        $display("FAIL wrapload_seg: cycle %0d got seg=%h required %h", k, seg_n, want);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    int   i0;
    for (int j = 0; j < 11; j++) begin
      if (j == 3) en = 1'b0;
      if (j == 7) begin
        en = 1'b1;
        i0 = m_idx;
      end
      cyc();
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL enable_sb: cycle %0d got %h required %h", j,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      if (j >= 3 && j < 7) begin
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
          failures++;
          $display("FAIL enable_off: cycle %0d got an=%h seg=%h dp=%b required f 7f 1",
                   j, an_n, seg_n, dp_n);
        end
      end
      if (j == 7) begin
        checks++;
        if (an_n !== ~(4'b0001 << i0)) begin
          failures++;
          $display("FAIL enable_resume: got an=%h required %h", an_n, ~(4'b0001 << i0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cw;
    value = 16'hBEEF; dp_in = 4'h0; blank_lz = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    void'(sb.pop_front());
    cw = (3 - m_idx) * 4 + (3 - m_presc);
    for (int j = 0; j < cw + 12; j++) begin
      if (j == cw + 6) load = 1'b1;
      if (j == cw + 9) rst_n = 1'b0;
      if (j == cw + 10) rst_n = 1'b1;
      cyc();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL midreset_sb: cycle %0d got %h required %h", j,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      if (j == cw + 9) begin
        checks++;
        if ({seg_n, dp_n, an_n, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
          failures++;
          $display("FAIL midreset_values: got seg=%h dp=%b an=%h fd=%b required 7f 1 f 0",
                   seg_n, dp_n, an_n, frame_done);
        end
      end
    end
    for (int k = 0; k < 32; k++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        failures++;
        $display("FAIL postreset_sb: cycle %0d got %h required %h", k,
                 {seg_n, dp_n, an_n, frame_done}, {e.seg, e.dp, e.an, e.fd});
      end
      checks++;
      if (seg_n !== 7'h40) begin
        failures++;
        $display("FAIL postreset_seg: cycle %0d got seg=%h required 40", k, seg_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_load_on_wrap();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
